// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor. It holds the free-running 64-bit mtime
// counter and the mtimecmp compare register. It raises a level timer interrupt
// while mtime >= mtimecmp. Software reaches it over a single-beat req/ack bus.
// Optional feature macro: CLINT_MSIP_EN. When it is defined, the MSIP register
// at offset 0x0000 exists and drives sw_interrupt. When it is not defined,
// 0x0000 behaves as unmapped and sw_interrupt is tied low.
module clint_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [15:0] bus_addr,
  input  logic [3:0]  bus_be,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic [63:0] mtime_o,
  output logic        timer_interrupt,
  output logic        sw_interrupt
);

  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 32'd1);

  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ack_q, ack_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          irq_q, irq_d;

  logic          accept_s;
  logic          wr_s;
  logic [15:0]   word_addr_s;
  logic          sel_cmp_lo_s, sel_cmp_hi_s, sel_mt_lo_s, sel_mt_hi_s;
  logic [31:0]   rd_mux_s;
  logic          addr_unused_s;

`ifdef CLINT_MSIP_EN
  logic          msip_q, msip_d;
  logic          sel_msip_s;
`endif

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  // A request is taken on any edge where no ack is outstanding. This limits throughput to one transfer per 2 cycles.
  assign accept_s      = bus_req & ~ack_q;
  assign wr_s          = accept_s & bus_we;
  assign word_addr_s   = {bus_addr[15:2], 2'b00};
  assign addr_unused_s = ^bus_addr[1:0];

  // Decode the word offset into register selects and read data.
  always_comb begin
    sel_cmp_lo_s = 1'b0;
    sel_cmp_hi_s = 1'b0;
    sel_mt_lo_s  = 1'b0;
    sel_mt_hi_s  = 1'b0;
    rd_mux_s     = 32'h0000_0000;
`ifdef CLINT_MSIP_EN
    sel_msip_s   = 1'b0;
`endif
    case (word_addr_s)
`ifdef CLINT_MSIP_EN
      16'h0000: begin
        sel_msip_s = 1'b1;
        rd_mux_s   = {31'h0000_0000, msip_q};
      end
`endif
      16'h4000: begin
        sel_cmp_lo_s = 1'b1;
        rd_mux_s     = mtimecmp_q[31:0];
      end
      16'h4004: begin
        sel_cmp_hi_s = 1'b1;
        rd_mux_s     = mtimecmp_q[63:32];
      end
      16'hBFF8: begin
        sel_mt_lo_s = 1'b1;
        rd_mux_s    = mtime_q[31:0];
      end
      16'hBFFC: begin
        sel_mt_hi_s = 1'b1;
        rd_mux_s    = mtime_q[63:32];
      end
      default: begin
        rd_mux_s = 32'h0000_0000;
      end
    endcase
  end

  // Next state: a software write to mtime overrides the tick and restarts the prescaler.
  always_comb begin
    mtime_d    = mtime_q;
    presc_d    = presc_q;
    mtimecmp_d = mtimecmp_q;
    ack_d      = accept_s;
    rdata_d    = accept_s ? rd_mux_s : 32'h0000_0000;
    irq_d      = (mtime_q >= mtimecmp_q);

    if (wr_s && sel_mt_lo_s) begin
      mtime_d[31:0] = merge_bytes(mtime_q[31:0], bus_wdata, bus_be);
      presc_d       = {PW{1'b0}};
    end else if (wr_s && sel_mt_hi_s) begin
      mtime_d[63:32] = merge_bytes(mtime_q[63:32], bus_wdata, bus_be);
      presc_d        = {PW{1'b0}};
    end else if (presc_q == PRESC_MAX) begin
      mtime_d = mtime_q + 64'd1;
      presc_d = {PW{1'b0}};
    end else begin
      presc_d = presc_q + PW'(1'b1);
    end

    if (wr_s && sel_cmp_lo_s) begin
      mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], bus_wdata, bus_be);
    end else if (wr_s && sel_cmp_hi_s) begin
      mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], bus_wdata, bus_be);
    end else begin
      mtimecmp_d = mtimecmp_q;
    end
  end

  // Timer state and bus response registers; reset also drops any in-flight transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtime_q    <= 64'h0000_0000_0000_0000;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      presc_q    <= {PW{1'b0}};
      ack_q      <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

`ifdef CLINT_MSIP_EN
  // Next MSIP value: only bit0 is storage, updated when byte lane 0 is enabled.
  always_comb begin
    if (wr_s && sel_msip_s && bus_be[0]) begin
      msip_d = bus_wdata[0];
    end else begin
      msip_d = msip_q;
    end
  end

  // MSIP storage register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      msip_q <= 1'b0;
    end else begin
      msip_q <= msip_d;
    end
  end

  assign sw_interrupt = msip_q;
`else
  assign sw_interrupt = 1'b0;
`endif

  assign bus_rdata       = rdata_q;
  assign bus_ack         = ack_q;
  assign mtime_o         = mtime_q;
  assign timer_interrupt = irq_q;

endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: runs two clint_timer instances, with TICK_DIV=1 and TICK_DIV=4,
// from one shared bus. Each instance is checked every cycle against a reference
// model. In that model, mtime = base + floor(cycles_since_base / TICK_DIV).
`timescale 1ns/1ps
module tb_clint_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [15:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;

  logic [31:0] rdata0, rdata1;
  logic        ack0, ack1, ti0, ti1, sw0, sw1;
  logic [63:0] mt0, mt1;

  clint_timer #(.TICK_DIV(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus_req(req), .bus_we(we), .bus_addr(addr),
    .bus_be(be), .bus_wdata(wdata), .bus_rdata(rdata0), .bus_ack(ack0),
    .mtime_o(mt0), .timer_interrupt(ti0), .sw_interrupt(sw0)
  );

  clint_timer #(.TICK_DIV(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus_req(req), .bus_we(we), .bus_addr(addr),
    .bus_be(be), .bus_wdata(wdata), .bus_rdata(rdata1), .bus_ack(ack1),
    .mtime_o(mt1), .timer_interrupt(ti1), .sw_interrupt(sw1)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [63:0]     m_base [2];
  longint unsigned m_n    [2];
  logic [63:0]     m_cmp  [2];
  logic            m_irq  [2];
  logic            m_msip;
  logic            e_ack, e_rd;
  logic [31:0]     e_rdata [2];

  int total, bad;

  function automatic longint unsigned td(int k);
    return (k == 0) ? 64'd1 : 64'd4;
  endfunction

  function automatic logic [63:0] mt(int k);
    return m_base[k] + (m_n[k] / td(k));
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old_v, logic [31:0] new_v, logic [3:0] b);
    logic [31:0] mask;
    mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  function automatic logic [31:0] rd_model(int k, logic [15:0] wa, logic [63:0] cur);
    case (wa)
`ifdef CLINT_MSIP_EN
      16'h0000: return {31'h0, m_msip};
`endif
      16'h4000: return m_cmp[k][31:0];
      16'h4004: return m_cmp[k][63:32];
      16'hBFF8: return cur[31:0];
      16'hBFFC: return cur[63:32];
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_base[k]  = 64'h0;
      m_n[k]     = 0;
      m_cmp[k]   = 64'hFFFF_FFFF_FFFF_FFFF;
      m_irq[k]   = 1'b0;
      e_rdata[k] = 32'h0;
    end
    m_msip = 1'b0;
    e_ack  = 1'b0;
    e_rd   = 1'b0;
  endtask

  task automatic chk(string tag, int k, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_dut(int k, logic [31:0] rd, logic ack, logic [63:0] mto, logic ti, logic sw);
    chk("ack", k, ack, e_ack);
    if (e_rd) chk("rdata", k, rd, e_rdata[k]);
    else if (!e_ack) chk("rdata_idle", k, rd, 64'h0);
    chk("mtime", k, mto, mt(k));
    chk("irq", k, ti, m_irq[k]);
    chk("sw", k, sw, m_msip);
  endtask

  // One clock: predict from pre-edge state and inputs, then compare #1 after the edge.
  task automatic tick();
    logic        acc;
    logic [15:0] wa;
    logic [63:0] cur [2];
    logic [31:0] rv  [2];
    acc = req && !e_ack;
    wa  = {addr[15:2], 2'b00};
    for (int k = 0; k < 2; k++) begin
      cur[k] = mt(k);
      rv[k]  = rd_model(k, wa, cur[k]);
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_irq[k]   = (cur[k] >= m_cmp[k]);
        m_n[k]     = m_n[k] + 1;
        e_rdata[k] = acc ? rv[k] : 32'h0;
      end
      e_ack = acc;
      e_rd  = acc && !we;
      if (acc && we) begin
        for (int k = 0; k < 2; k++) begin
          case (wa)
`ifdef CLINT_MSIP_EN
            16'h0000: if (be[0]) m_msip = wdata[0];
`endif
            16'h4000: m_cmp[k][31:0]  = merge(m_cmp[k][31:0], wdata, be);
            16'h4004: m_cmp[k][63:32] = merge(m_cmp[k][63:32], wdata, be);
            16'hBFF8: begin m_base[k] = {cur[k][63:32], merge(cur[k][31:0], wdata, be)}; m_n[k] = 0; end
            16'hBFFC: begin m_base[k] = {merge(cur[k][63:32], wdata, be), cur[k][31:0]}; m_n[k] = 0; end
            default: ;
          endcase
        end
      end
    end
    #1;
    check_dut(0, rdata0, ack0, mt0, ti0, sw0);
    check_dut(1, rdata1, ack1, mt1, ti1, sw1);
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic bus_start(logic w, logic [15:0] a, logic [3:0] b, logic [31:0] d);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    tick();
  endtask

  task automatic bus_end();
    req = 1'b0;
    tick();
  endtask

  int          acks;
  int          sel;
  logic [15:0] ra;

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 16'h0; be = 4'h0; wdata = 32'h0;
    model_reset();
    idle(3);
    chk("rst_mtime", 0, mt0, 64'h0);
    chk("rst_ack", 0, ack0, 64'h0);
    chk("rst_rdata", 0, rdata0, 64'h0);
    chk("rst_irq", 1, ti1, 64'h0);
    chk("rst_sw", 0, sw0, 64'h0);

    // Free-running count with TICK_DIV=1.
    rst_n = 1'b1;
    idle(10);
    chk("idle10_mtime", 0, mt0, 64'd10);
    chk("idle10_irq", 0, ti0, 64'h0);
    chk("idle10_ack", 0, ack0, 64'h0);

    // Compare hit, then rewrite mtimecmp higher.
    bus_start(1'b1, 16'h4000, 4'hF, 32'd20); bus_end();
    bus_start(1'b1, 16'h4004, 4'hF, 32'd0);  bus_end();
    for (int i = 0; i < 40 && mt(0) != 64'd20; i++) tick();
    chk("cmp_reach_mtime", 0, mt0, 64'd20);
    chk("cmp_reach_irq", 0, ti0, 64'h0);
    tick();
    chk("cmp_irq_rise", 0, ti0, 64'h1);
    idle(70);
    chk("cmp_irq_held", 0, ti0, 64'h1);
    chk("cmp_irq_td4", 1, ti1, 64'h1);
    bus_start(1'b1, 16'h4004, 4'hF, 32'd1);
    chk("irq_fall_lat", 0, ti0, 64'h1);
    bus_end();
    chk("irq_fall", 0, ti0, 64'h0);

    // 64-bit wrap and low-to-high carry.
    bus_start(1'b1, 16'hBFFC, 4'hF, 32'hFFFF_FFFF); bus_end();
    bus_start(1'b1, 16'hBFF8, 4'hF, 32'hFFFF_FFFF);
    chk("wrap_ones", 0, mt0, 64'hFFFF_FFFF_FFFF_FFFF);
    bus_end();
    chk("wrap_zero", 0, mt0, 64'h0);
    bus_start(1'b1, 16'hBFFC, 4'hF, 32'h0); bus_end();
    bus_start(1'b1, 16'hBFF8, 4'hF, 32'hFFFF_FFFF);
    chk("carry_pre", 0, mt0, 64'h0000_0000_FFFF_FFFF);
    bus_end();
    chk("carry", 0, mt0, 64'h0000_0001_0000_0000);

    // TICK_DIV=4: the write lands on the cycle a tick is due.
    for (int i = 0; i < 8 && (m_n[1] % 4) != 3; i++) tick();
    bus_start(1'b1, 16'hBFF8, 4'hF, 32'd100);
    chk("td4_hold0", 1, mt1[31:0], 64'd100);
    bus_end();
    chk("td4_hold1", 1, mt1[31:0], 64'd100);
    tick(); chk("td4_hold2", 1, mt1[31:0], 64'd100);
    tick(); chk("td4_hold3", 1, mt1[31:0], 64'd100);
    tick(); chk("td4_inc", 1, mt1[31:0], 64'd101);

    // Request held high: one ack every other cycle.
    acks = 0;
    req = 1'b1; we = 1'b0; addr = 16'hBFF8; be = 4'h0;
    for (int i = 0; i < 8; i++) begin
      tick();
      acks += int'(ack0);
    end
    chk("held_ack_count", 0, acks, 64'd4);
    req = 1'b0;
    tick();

    // Byte-enabled write, read-back, and an unmapped read.
    bus_start(1'b1, 16'h4000, 4'b0010, 32'hAABB_CCDD); bus_end();
    bus_start(1'b0, 16'h4000, 4'h0, 32'h0);
    chk("be_readback", 0, rdata0, 64'h0000_CC14);
    bus_end();
    bus_start(1'b0, 16'h1234, 4'h0, 32'h0);
    chk("unmapped_ack", 0, ack0, 64'h1);
    chk("unmapped_rd", 0, rdata0, 64'h0);
    bus_end();

`ifdef CLINT_MSIP_EN
    bus_start(1'b1, 16'h0000, 4'h1, 32'h1);
    chk("msip_sw", 0, sw0, 64'h1);
    bus_end();
    bus_start(1'b0, 16'h0000, 4'h0, 32'h0);
    chk("msip_rd", 0, rdata0, 64'h1);
    bus_end();
`else
    bus_start(1'b1, 16'h0000, 4'hF, 32'hFFFF_FFFF);
    chk("nomsip_sw", 0, sw0, 64'h0);
    bus_end();
    bus_start(1'b0, 16'h0000, 4'h0, 32'h0);
    chk("nomsip_rd", 0, rdata0, 64'h0);
    bus_end();
`endif

    // Randomized transfers against the model.
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0: ra = 16'h0000;
        1: ra = 16'h4000;
        2: ra = 16'h4004;
        3: ra = 16'hBFF8;
        4: ra = 16'hBFFC;
        5: ra = 16'h1234;
        default: ra = 16'($urandom);
      endcase
      ra[1:0] = 2'($urandom);
      bus_start(1'($urandom_range(0, 1)), ra, 4'($urandom), 32'($urandom));
      bus_end();
      idle($urandom_range(0, 3));
    end

    // Reset with a write pending: no ack, outputs at reset values, write dropped.
    req = 1'b1; we = 1'b1; addr = 16'h4000; be = 4'hF; wdata = 32'h0;
    rst_n = 1'b0;
    tick();
    chk("rstmid_ack", 0, ack0, 64'h0);
    chk("rstmid_mtime", 0, mt0, 64'h0);
    chk("rstmid_irq", 0, ti0, 64'h0);
    chk("rstmid_sw", 0, sw0, 64'h0);
    chk("rstmid_rdata", 1, rdata1, 64'h0);
    tick();
    req = 1'b0;
    rst_n = 1'b1;
    idle(3);
    bus_start(1'b0, 16'h4000, 4'h0, 32'h0);
    chk("rst_drop_write", 0, rdata0, 64'hFFFF_FFFF);
    bus_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
